mips_debug_ctrl: RTL and testbench
==================================

# mips_debug_ctrl

Parametrised program-load and execution controller for the MIPS pipeline. It assembles a byte stream from the serial receiver into instruction words and writes them into instruction memory through the core's load port (instruction, address, loading). It then gates the pipeline clock-enable in continuous-run or single-step mode, stopping on the core's halt indication. It sits between the UART receiver and the pipeline top, and replaces direct testbench drive of the load port.

## Interface
- DATA_WIDTH, 32, instruction/address word width; must be a multiple of BYTE_WIDTH.
- BYTE_WIDTH, 8, width of one received symbol.
- IMEM_DEPTH, 256, instruction memory depth in words; maximum words per load.
- HALT_WORD, 32'hFFFF_FFFF, word value that terminates a load. It is written to memory before the load ends.
- CNT_WIDTH, 16, width of the executed-cycle counter.

Ports:
- i_clock  in  1  single clock, rising edge.
- i_reset  in  1  asynchronous, active-low reset.
- i_rx_data  in  BYTE_WIDTH  received symbol.
- i_rx_valid  in  1  symbol valid; consumed when i_rx_valid && o_rx_ready.
- o_rx_ready  out  1  controller accepts a symbol this cycle.
- i_halt  in  1  core reports that a HALT instruction has retired.
- o_instruccion  out  DATA_WIDTH  assembled word to instruction memory.
- o_address  out  DATA_WIDTH  word index for the write, zero-extended.
- o_loading  out  1  one-cycle write strobe to instruction memory.
- o_core_enable  out  1  pipeline clock-enable.
- o_state  out  2  current state: 0 IDLE, 1 LOAD, 2 RUN, 3 STEP.
- o_cycle_count  out  CNT_WIDTH  cycles with o_core_enable high since the last run/step entry.
- o_load_overflow  out  1  sticky flag: a load hit IMEM_DEPTH without seeing HALT_WORD.

## Operation
- Symbols are consumed only on a handshake. Unrecognised command symbols are consumed and ignored.
- IDLE:
  - 'L' (8'h4C): clear the word index and byte counter, clear o_load_overflow, go to LOAD.
  - 'C' (8'h43): clear o_cycle_count, go to RUN.
  - 'S' (8'h53): clear o_cycle_count, go to STEP.
- LOAD:
  - Each accepted symbol is shifted in little-endian; the first symbol lands in bits [BYTE_WIDTH-1:0].
  - After DATA_WIDTH/BYTE_WIDTH symbols: drive o_instruccion = word and o_address = index, pulse o_loading, increment the index, reset the byte counter.
  - If the word equals HALT_WORD, go to IDLE after its write.
  - If instead the index reaches IMEM_DEPTH, set o_load_overflow and go to IDLE. There is no wrap.
- RUN:
  - o_core_enable is held high.
  - i_halt high takes the controller to IDLE.
  - o_rx_ready is low throughout RUN.
- STEP:
  - 'S' produces exactly one cycle of o_core_enable.
  - 'E' (8'h45) returns to IDLE.
  - i_halt high takes the controller to IDLE.
  - If i_halt and a symbol handshake coincide, i_halt wins: the symbol is consumed and dropped.
- o_cycle_count increments on every cycle with o_core_enable high and saturates at all-ones.
- o_rx_ready is high in IDLE and LOAD. In STEP it is high except during the o_core_enable pulse cycle and the cycle that follows it.

## Timing
- Reset: every output is 0 and the state is IDLE. Asynchronous assertion takes effect immediately.
  - A load in progress is abandoned; the partial word is discarded and the next load starts at index 0.
  - o_core_enable drops immediately.
- All outputs are registered.
- o_loading is high for exactly one cycle: the cycle after the last symbol of a word is accepted. o_instruccion and o_address are valid in that cycle and hold until the next write.
- o_state changes the cycle after the triggering handshake or i_halt sample.
- RUN: o_core_enable rises the cycle after 'C' is accepted and falls the cycle after i_halt is sampled high.
- STEP: o_core_enable is high the single cycle after 'S' is accepted.
- Back-to-back symbols, one per cycle, are sustained in LOAD: one word per DATA_WIDTH/BYTE_WIDTH cycles.

## Test plan
- Load 'L' then bytes 20,00,01,00 | FF,FF,FF,FF -> o_loading pulses twice:
  - (o_address 0, o_instruccion 32'h0001_0020);
  - (o_address 1, o_instruccion 32'hFFFF_FFFF);
  - then o_state = 0 and o_load_overflow = 0.
- Overflow with IMEM_DEPTH=4: load 4 non-HALT words -> 4 strobes at addresses 0..3, o_load_overflow = 1, o_state = 0. A fifth word's bytes are ignored as commands.
- Continuous run: 'C', hold i_halt low 10 cycles, then pulse it -> o_core_enable is high exactly 11 cycles, o_cycle_count = 11, o_rx_ready is low during RUN.
- Stepping: 'S', then 'S','S','S' spaced 4 cycles apart, then 'E' -> three isolated 1-cycle o_core_enable pulses, o_cycle_count = 3, final o_state = 0.
- Halt priority: in STEP, assert i_halt in the same cycle as an 'S' handshake -> no o_core_enable pulse, o_state = 0 next cycle.
- Reset mid-load: after 'L' and 2 bytes, pulse i_reset low -> all outputs 0. A new 'L' plus 4 bytes then writes to o_address 0.

Source files
------------

// File: rtl/mips_debug_ctrl.sv
//------------------------------------------------------------------------------
// mips_debug_ctrl : serial program loader and run/step clock-enable controller
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mips_debug_ctrl #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    BYTE_WIDTH = 8,
    parameter int                    IMEM_DEPTH = 256,
    parameter logic [DATA_WIDTH-1:0] HALT_WORD  = 32'hFFFF_FFFF,
    parameter int                    CNT_WIDTH  = 16
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic [BYTE_WIDTH-1:0] i_rx_data,
    input  logic                  i_rx_valid,
    output logic                  o_rx_ready,
    input  logic                  i_halt,
    output logic [DATA_WIDTH-1:0] o_instruccion,
    output logic [DATA_WIDTH-1:0] o_address,
    output logic                  o_loading,
    output logic                  o_core_enable,
    output logic [1:0]            o_state,
    output logic [CNT_WIDTH-1:0]  o_cycle_count,
    output logic                  o_load_overflow
);

    localparam int SYMS   = DATA_WIDTH / BYTE_WIDTH;
    localparam int BCNT_W = (SYMS > 1) ? $clog2(SYMS) : 1;
    localparam int IDX_W  = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;

    localparam logic [BCNT_W-1:0] LAST_SYM = BCNT_W'(SYMS - 1);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(IMEM_DEPTH - 1);

    localparam logic [BYTE_WIDTH-1:0] CMD_LOAD = BYTE_WIDTH'(8'h4C);
    localparam logic [BYTE_WIDTH-1:0] CMD_CONT = BYTE_WIDTH'(8'h43);
    localparam logic [BYTE_WIDTH-1:0] CMD_STEP = BYTE_WIDTH'(8'h53);
    localparam logic [BYTE_WIDTH-1:0] CMD_END  = BYTE_WIDTH'(8'h45);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;
    localparam logic [1:0] ST_STEP = 2'd3;

    logic [1:0]            state, state_nx;
    logic [DATA_WIDTH-1:0] shreg, shreg_nx;
    logic [BCNT_W-1:0]     bcnt, bcnt_nx;
    logic [IDX_W-1:0]      idx, idx_nx;
    logic [DATA_WIDTH-1:0] instr_nx, addr_nx;
    logic                  loading_nx, core_en_nx, rx_ready_nx, ovf_nx;
    logic [CNT_WIDTH-1:0]  cnt_nx;

    logic                             hs;
    logic [DATA_WIDTH+BYTE_WIDTH-1:0] cat;
    logic [DATA_WIDTH-1:0]            word;

    // Little-endian assembly: each new symbol enters at the top and the
    // oldest symbol ends up in the least-significant position.
    assign hs   = i_rx_valid && o_rx_ready;
    assign cat  = {i_rx_data, shreg};
    assign word = cat[DATA_WIDTH+BYTE_WIDTH-1:BYTE_WIDTH];

    always_comb begin
        state_nx    = state;
        shreg_nx    = shreg;
        bcnt_nx     = bcnt;
        idx_nx      = idx;
        instr_nx    = o_instruccion;
        addr_nx     = o_address;
        loading_nx  = 1'b0;
        core_en_nx  = 1'b0;
        ovf_nx      = o_load_overflow;
        cnt_nx      = o_cycle_count;

        if (o_core_enable && (o_cycle_count != {CNT_WIDTH{1'b1}})) begin
            cnt_nx = o_cycle_count + 1'b1;
        end

        case (state)
            ST_IDLE: begin
                if (hs) begin
                    if (i_rx_data == CMD_LOAD) begin
                        state_nx = ST_LOAD;
                        idx_nx   = '0;
                        bcnt_nx  = '0;
                        ovf_nx   = 1'b0;
                    end else if (i_rx_data == CMD_CONT) begin
                        state_nx   = ST_RUN;
                        cnt_nx     = '0;
                        core_en_nx = 1'b1;
                    end else if (i_rx_data == CMD_STEP) begin
                        state_nx = ST_STEP;
                        cnt_nx   = '0;
                    end
                end
            end
            ST_LOAD: begin
                if (hs) begin
                    shreg_nx = word;
                    if (bcnt == LAST_SYM) begin
                        instr_nx   = word;
                        addr_nx    = DATA_WIDTH'(idx);
                        loading_nx = 1'b1;
                        idx_nx     = idx + 1'b1;
                        bcnt_nx    = '0;
                        // HALT_WORD takes precedence when it lands in the last slot.
                        if (word == HALT_WORD) begin
                            state_nx = ST_IDLE;
                        end else if (idx == LAST_IDX) begin
                            state_nx = ST_IDLE;
                            ovf_nx   = 1'b1;
                        end
                    end else begin
                        bcnt_nx = bcnt + 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (i_halt) begin
                    state_nx = ST_IDLE;
                end else begin
                    core_en_nx = 1'b1;
                end
            end
            default: begin
                if (i_halt) begin
                    state_nx = ST_IDLE;
                end else if (hs) begin
                    if (i_rx_data == CMD_STEP) begin
                        core_en_nx = 1'b1;
                    end else if (i_rx_data == CMD_END) begin
                        state_nx = ST_IDLE;
                    end
                end
            end
        endcase

        // In STEP the receiver is held off for the pulse cycle and the one after.
        case (state_nx)
            ST_RUN:  rx_ready_nx = 1'b0;
            ST_STEP: rx_ready_nx = !core_en_nx && !o_core_enable;
            default: rx_ready_nx = 1'b1;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state           <= ST_IDLE;
            shreg           <= '0;
            bcnt            <= '0;
            idx             <= '0;
            o_instruccion   <= '0;
            o_address       <= '0;
            o_loading       <= 1'b0;
            o_core_enable   <= 1'b0;
            o_rx_ready      <= 1'b0;
            o_cycle_count   <= '0;
            o_load_overflow <= 1'b0;
        end else begin
            state           <= state_nx;
            shreg           <= shreg_nx;
            bcnt            <= bcnt_nx;
            idx             <= idx_nx;
            o_instruccion   <= instr_nx;
            o_address       <= addr_nx;
            o_loading       <= loading_nx;
            o_core_enable   <= core_en_nx;
            o_rx_ready      <= rx_ready_nx;
            o_cycle_count   <= cnt_nx;
            o_load_overflow <= ovf_nx;
        end
    end

    assign o_state = state;

endmodule

`default_nettype wire

// File: tb/tb_mips_debug_ctrl.sv
//------------------------------------------------------------------------------
// tb_mips_debug_ctrl : randomized self-checking bench for mips_debug_ctrl
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_mips_debug_ctrl;

    localparam int          DW    = 32;
    localparam int          BW    = 8;
    localparam int          DEPTH = 4;
    localparam int          CW    = 4;
    localparam logic [31:0] HALT  = 32'hFFFF_FFFF;
    localparam int          CMAX  = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [BW-1:0] rx_data = '0;
    logic          rx_valid = 1'b0;
    logic          halt = 1'b0;
    logic          rx_ready;
    logic [DW-1:0] instr;
    logic [DW-1:0] addr;
    logic          loading;
    logic          core_enable;
    logic [1:0]    state;
    logic [CW-1:0] cycle_count;
    logic          load_overflow;

    mips_debug_ctrl #(
        .DATA_WIDTH (DW),
        .BYTE_WIDTH (BW),
        .IMEM_DEPTH (DEPTH),
        .HALT_WORD  (HALT),
        .CNT_WIDTH  (CW)
    ) dut (
        .i_clock         (clk),
        .i_reset         (rst_n),
        .i_rx_data       (rx_data),
        .i_rx_valid      (rx_valid),
        .o_rx_ready      (rx_ready),
        .i_halt          (halt),
        .o_instruccion   (instr),
        .o_address       (addr),
        .o_loading       (loading),
        .o_core_enable   (core_enable),
        .o_state         (state),
        .o_cycle_count   (cycle_count),
        .o_load_overflow (load_overflow)
    );

    always #5 clk = ~clk;

    int tests  = 0;
    int fails  = 0;
    int en_cycles = 0;
    int stalls = 0;
    logic [63:0] exp_wr[$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Write scoreboard and per-cycle protocol observations.
    always @(negedge clk) begin
        if (core_enable) en_cycles++;
        if (loading) begin
            check_eq("write_expected", 64'(exp_wr.size() > 0), 64'd1);
            if (exp_wr.size() > 0) begin
                logic [63:0] e;
                e = exp_wr.pop_front();
                check_eq("write_addr", 64'(addr), 64'(e[63:32]));
                check_eq("write_data", 64'(instr), 64'(e[31:0]));
            end
        end
        if (state == 2'd2) check_eq("run_rx_ready", 64'(rx_ready), 64'd0);
        if (state == 2'd3 && core_enable) check_eq("step_rx_ready", 64'(rx_ready), 64'd0);
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge; presents one symbol and returns at the negedge after its handshake.
    task automatic send(input logic [7:0] b);
        int n = 0;
        while (!rx_ready && n < 50) begin
            @(negedge clk);
            n++;
            stalls++;
        end
        check_eq("rx_ready_wait", 64'(rx_ready), 64'd1);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    // Reference: words go to addresses 0,1,.. until HALT or the memory is full.
    task automatic do_load(input logic [31:0] ws[$]);
        bit ended = 0;
        bit ovf   = 0;
        int st0;
        send(8'h4C);
        st0 = stalls;
        for (int i = 0; i < ws.size() && !ended; i++) begin
            logic [31:0] w;
            w = ws[i];
            exp_wr.push_back({32'(i), w});
            for (int b = 0; b < 4; b++) send(w[8*b +: 8]);
            if (w == HALT) ended = 1;
            else if (i + 1 == DEPTH) begin
                ended = 1;
                ovf   = 1;
            end
        end
        check_eq("load_stalls", 64'(stalls - st0), 64'd0);
        idle(2);
        check_eq("load_writes_left", 64'(exp_wr.size()), 64'd0);
        check_eq("load_state", 64'(state), ended ? 64'd0 : 64'd1);
        check_eq("load_ovf", 64'(load_overflow), 64'(ovf));
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        w = $urandom;
        if (w == HALT) w = 32'h1234_5678;
        return w;
    endfunction

    task automatic run_test(input int hold);
        int base;
        int exp_n;
        base = en_cycles;
        send(8'h43);
        check_eq("run_enable_rise", 64'(core_enable), 64'd1);
        check_eq("run_state", 64'(state), 64'd2);
        repeat (hold) @(negedge clk);
        halt = 1'b1;
        @(negedge clk);
        halt = 1'b0;
        check_eq("run_enable_fall", 64'(core_enable), 64'd0);
        check_eq("run_exit_state", 64'(state), 64'd0);
        idle(1);
        exp_n = hold + 1;
        check_eq("run_en_cycles", 64'(en_cycles - base), 64'(exp_n));
        check_eq("run_count", 64'(cycle_count), 64'((exp_n > CMAX) ? CMAX : exp_n));
    endtask

    task automatic step_test(input int nsteps, input int gap);
        int base;
        base = en_cycles;
        send(8'h53);
        check_eq("step_state", 64'(state), 64'd3);
        for (int i = 0; i < nsteps; i++) begin
            send(8'h53);
            idle(gap);
        end
        send(8'h45);
        idle(2);
        check_eq("step_pulses", 64'(en_cycles - base), 64'(nsteps));
        check_eq("step_count", 64'(cycle_count), 64'(nsteps));
        check_eq("step_exit_state", 64'(state), 64'd0);
    endtask

    initial begin
        logic [31:0] ws[$];
        int base;

        // Reset state
        idle(1);
        check_eq("rst_state", 64'(state), 64'd0);
        check_eq("rst_ready", 64'(rx_ready), 64'd0);
        check_eq("rst_outs", {instr, addr}, 64'd0);
        check_eq("rst_flags", 64'({loading, core_enable, load_overflow, cycle_count}), 64'd0);
        rst_n = 1'b1;
        idle(1);
        check_eq("idle_ready", 64'(rx_ready), 64'd1);

        // Directed load then HALT
        ws = '{32'h0001_0020, HALT};
        do_load(ws);
        check_eq("instr_hold", 64'(instr), 64'(HALT));
        check_eq("addr_hold", 64'(addr), 64'd1);

        // Random loads; k=3 puts HALT exactly in the last slot
        for (int t = 0; t < 4; t++) begin
            int k;
            k = (t == 0) ? 3 : int'($urandom_range(0, 3));
            ws = {};
            for (int i = 0; i < k; i++) ws.push_back(rand_word());
            ws.push_back(HALT);
            do_load(ws);
        end

        // Overflow, then a fifth word's bytes are plain ignored commands
        ws = {};
        for (int i = 0; i < 5; i++) ws.push_back(rand_word());
        do_load(ws);
        for (int b = 0; b < 4; b++) begin
            logic [7:0] x;
            x = 8'($urandom);
            if (x == 8'h4C || x == 8'h43 || x == 8'h53) x = 8'h11;
            send(x);
        end
        idle(2);
        check_eq("ovf_ignore_state", 64'(state), 64'd0);
        check_eq("ovf_sticky", 64'(load_overflow), 64'd1);
        ws = '{HALT};
        do_load(ws);

        // Continuous run: directed, saturating, random
        run_test(10);
        run_test(18);
        run_test(int'($urandom_range(1, 20)));

        // Stepping
        step_test(3, 4);
        step_test(int'($urandom_range(1, 5)), int'($urandom_range(0, 4)));

        // Halt beats a coincident step request
        base = en_cycles;
        send(8'h53);
        check_eq("hp_ready", 64'(rx_ready), 64'd1);
        rx_valid = 1'b1;
        rx_data  = 8'h53;
        halt     = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        halt     = 1'b0;
        check_eq("hp_state", 64'(state), 64'd0);
        check_eq("hp_enable", 64'(core_enable), 64'd0);
        idle(3);
        check_eq("hp_pulses", 64'(en_cycles - base), 64'd0);
        check_eq("hp_count", 64'(cycle_count), 64'd0);

        // Asynchronous reset mid-load
        send(8'h4C);
        send(8'h12);
        send(8'h34);
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_state", 64'(state), 64'd0);
        check_eq("arst_outs", {instr, addr}, 64'd0);
        check_eq("arst_flags", 64'({rx_ready, loading, core_enable, load_overflow, cycle_count}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);
        ws = '{rand_word(), HALT};
        do_load(ws);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, tests %0d", tests);
        $fatal(1);
    end

endmodule

`default_nettype wire
